// File: rtl/qm_icache_refill.sv
// Miss/refill and flush sequencer for the direct-mapped instruction cache.
// Fetches a 4-word line in order, writes it back in one strobe, and pulses the cache's valid-polarity toggle.
module qm_icache_refill #(
    parameter int TAG_W   = 16,
    parameter int INDEX_W = 12,
    parameter int LINE_W  = 1 + TAG_W + 4 * 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                miss,
    input  logic [31:0]         miss_address,
    input  logic                valid_bit,
    input  logic                flush_req,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata,
    output logic                fill_we,
    output logic [INDEX_W-1:0]  fill_index,
    output logic [LINE_W-1:0]   fill_line,
    output logic                flush_toggle,
    output logic                busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [3:0][31:0]   words_q, words_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               pend_q, pend_d;
    logic               guard_q, guard_d;

    logic [TAG_W-1:0]   miss_tag;
    logic [INDEX_W-1:0] miss_index;
    logic [1:0]         k_next;
    logic               guard_hit;
    logic               unused_addr_lsb;

    assign miss_tag        = miss_address[31:32-TAG_W];
    assign miss_index      = miss_address[INDEX_W+3:4];
    assign unused_addr_lsb = ^miss_address[3:0];
    assign k_next          = k_q + 2'd1;

    // The cache's hit shows up one cycle after the write, so a still-asserted miss for that line is stale.
    assign guard_hit = guard_q && (miss_tag == tag_q) && (miss_index == index_q);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tag_d      = tag_q;
        index_d    = index_q;
        words_d    = words_q;
        mem_addr_d = mem_addr_q;
        pend_d     = pend_q;
        guard_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_req || pend_q) begin
                    state_d = S_FLUSH;
                end else if (miss && !guard_hit) begin
                    tag_d      = miss_tag;
                    index_d    = miss_index;
                    k_d        = 2'd0;
                    mem_addr_d = {miss_tag, miss_index, 4'b0000};
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (flush_req) pend_d = 1'b1;
                if (mem_ack) begin
                    words_d[k_q] = mem_rdata;
                    if (k_q == 2'd3) begin
                        state_d = S_WRITE;
                    end else begin
                        k_d        = k_next;
                        mem_addr_d = {tag_q, index_q, k_next, 2'b00};
                    end
                end
            end
            S_WRITE: begin
                guard_d = 1'b1;
                if (flush_req) pend_d = 1'b1;
                state_d = (pend_q || flush_req) ? S_FLUSH : S_IDLE;
            end
            default: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            k_q        <= 2'd0;
            tag_q      <= '0;
            index_q    <= '0;
            words_q    <= '0;
            mem_addr_q <= '0;
            pend_q     <= 1'b0;
            guard_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            words_q    <= words_d;
            mem_addr_q <= mem_addr_d;
            pend_q     <= pend_d;
            guard_q    <= guard_d;
        end
    end

    assign mem_req      = (state_q == S_FETCH);
    assign mem_addr     = mem_addr_q;
    assign fill_we      = (state_q == S_WRITE);
    assign flush_toggle = (state_q == S_FLUSH);
    assign busy         = (state_q != S_IDLE);
    assign fill_index   = index_q;
    // Polarity is taken live in the write cycle so a same-cycle flip elsewhere is honoured.
    assign fill_line    = {valid_bit & fill_we, tag_q, words_q};

endmodule

// File: tb/tb_qm_icache_refill.sv
// Directed bench for qm_icache_refill: refill timing, wait states, flush ordering, reset abort and restart guard.
`timescale 1ns/1ps
module tb_qm_icache_refill;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss;
    logic [31:0]  miss_address;
    logic         valid_bit;
    logic         flush_req;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         fill_we;
    logic [11:0]  fill_index;
    logic [144:0] fill_line;
    logic         flush_toggle;
    logic         busy;

    int checks = 0;
    int errors = 0;

    qm_icache_refill dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_address(miss_address),
        .valid_bit(valid_bit), .flush_req(flush_req), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_index(fill_index), .fill_line(fill_line),
        .flush_toggle(flush_toggle), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [144:0] got, input logic [144:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Caller is in an IDLE cycle; returns in the WRITE cycle.
    task automatic refill(input logic [31:0] addr, input logic [31:0] d0, input int wt,
                          input int flush_at, input int exp_lat);
        int lat;
        logic [31:0]  exp_a;
        logic [144:0] exp_line;
        miss = 1'b1; miss_address = addr; mem_ack = 1'b0;
        lat = 1;
        step(); lat++;
        for (int k = 0; k < 4; k++) begin
            exp_a = {addr[31:4], 4'(k * 4)};
            for (int w = 0; w < wt; w++) begin
                chk("wait_req", mem_req, 1'b1);
                chk("wait_addr", mem_addr, exp_a);
                step(); lat++;
            end
            chk("fetch_req", mem_req, 1'b1);
            chk("fetch_addr", mem_addr, exp_a);
            mem_ack = 1'b1; mem_rdata = d0 + 32'(k);
            if (k == flush_at) flush_req = 1'b1;
            step(); lat++;
            flush_req = 1'b0; mem_ack = 1'b0;
        end
        exp_line = {1'b1, addr[31:16], d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
        chk("fill_we", fill_we, 1'b1);
        chk("write_req", mem_req, 1'b0);
        chk("write_toggle", flush_toggle, 1'b0);
        chk("fill_index", fill_index, addr[15:4]);
        chk("fill_line", fill_line, exp_line);
        chk("latency", lat, exp_lat);
    endtask

    initial begin
        reset = 1'b0; miss = 1'b0; miss_address = '0; valid_bit = 1'b1;
        flush_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", fill_we, 1'b0);
        chk("rst_toggle", flush_toggle, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_index", fill_index, 12'h0);
        chk("rst_line", fill_line, 145'h0);
        reset = 1'b1;
        step();

        // Zero-wait refill, then the same miss lingering into the guard cycle.
        refill(32'h1234_5678, 32'hA0, 0, -1, 6);
        chk("t1_line_const", fill_line,
            {1'b1, 16'h1234, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
        step();
        chk("t6_idle", busy, 1'b0);
        step();
        chk("t6_no_restart", busy, 1'b0);
        chk("t6_no_req", mem_req, 1'b0);
        miss = 1'b0;
        step();

        // Three wait cycles per word.
        refill(32'h1234_5678, 32'hA0, 3, -1, 18);
        step();
        miss = 1'b0;
        step();

        // Flush and miss together in IDLE: flush first.
        miss = 1'b1; miss_address = 32'h55AA_1230; flush_req = 1'b1;
        step();
        chk("t3_toggle", flush_toggle, 1'b1);
        chk("t3_req", mem_req, 1'b0);
        chk("t3_busy", busy, 1'b1);
        flush_req = 1'b0;
        step();
        chk("t3_toggle_off", flush_toggle, 1'b0);
        chk("t3_idle", busy, 1'b0);
        refill(32'h55AA_1230, 32'hC0, 0, -1, 6);
        step();
        miss = 1'b0;
        step();

        // Flush pulsed while word 2 is fetched.
        refill(32'h0000_2340, 32'hB0, 0, 2, 6);
        step();
        miss = 1'b0;
        chk("t4_toggle", flush_toggle, 1'b1);
        chk("t4_we_off", fill_we, 1'b0);
        step();
        chk("t4_idle", busy, 1'b0);
        chk("t4_toggle_off", flush_toggle, 1'b0);

        // Reset during word 1 abandons the refill.
        miss = 1'b1; miss_address = 32'h0F0F_0F00;
        step();
        chk("t5_addr0", mem_addr, 32'h0F0F_0F00);
        mem_ack = 1'b1; mem_rdata = 32'h11;
        step();
        mem_ack = 1'b0;
        chk("t5_addr1", mem_addr, 32'h0F0F_0F04);
        chk("t5_req1", mem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("t5_req_rst", mem_req, 1'b0);
        chk("t5_busy_rst", busy, 1'b0);
        chk("t5_addr_rst", mem_addr, 32'h0);
        miss = 1'b0;
        #3 reset = 1'b1;
        step();
        mem_ack = 1'b1;
        step();
        chk("t5_stray_busy", busy, 1'b0);
        chk("t5_stray_req", mem_req, 1'b0);
        mem_ack = 1'b0;

        // New address during the guard cycle must start a refill.
        refill(32'h0000_1230, 32'hD0, 0, -1, 6);
        step();
        miss_address = 32'h0000_1240;
        step();
        chk("t6_new_busy", busy, 1'b1);
        chk("t6_new_addr", mem_addr, 32'h0000_1240);
        reset = 1'b0; miss = 1'b0;
        #2 reset = 1'b1;
        step();
        chk("t6_after_rst", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
